// File: rtl/pn_age_scheduler_pkg.sv
// pn_age_scheduler_pkg: flit layout, default sizes, age ceiling helper.
// Optional feature macro: PN_GOLDEN_EN (lowers the age ceiling by one).
package pn_age_scheduler_pkg;

  localparam int WIDTH_INTERNAL_PV = 32;
  localparam int POS_TIME_LSB      = 16;
  localparam int POS_TIME_W        = 8;
  localparam int EPOCH_LEN_DEF     = 256;

  // Golden mode reserves the all-ones age for the override.
  function automatic int age_max(input int w);
`ifdef PN_GOLDEN_EN
    return (1 << w) - 2;
`else
    return (1 << w) - 1;
`endif
  endfunction

endpackage

// File: rtl/pn_age_scheduler_age_sat_inc.sv
// age_sat_inc: saturating W-bit increment, clamped to i_max.
// Ports: i_age, i_max in; o_age result; o_hit = just reached i_max.
module age_sat_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_age,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_age,
  output logic         o_hit
);

  logic w_below;

  assign w_below = i_age < i_max;
  assign o_age   = w_below ? i_age + W'(1) : i_max;
  assign o_hit   = w_below && (o_age == i_max);

endmodule

// File: rtl/pn_age_scheduler.sv
// pn_age_scheduler: input register stage, flit aging, golden rotation.
// Ports: clk, reset, in_valid, din0..3, hold -> dout0..3, out_valid,
// golden_port, sat_event. Optional feature macro: PN_GOLDEN_EN.
module pn_age_scheduler
  import pn_age_scheduler_pkg::*;
#(
  parameter int TIME_W    = POS_TIME_W,
  parameter int EPOCH_LEN = EPOCH_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   in_valid,
  input  logic [WIDTH_INTERNAL_PV-1:0] din0,
  input  logic [WIDTH_INTERNAL_PV-1:0] din1,
  input  logic [WIDTH_INTERNAL_PV-1:0] din2,
  input  logic [WIDTH_INTERNAL_PV-1:0] din3,
  input  logic                         hold,
  output logic [WIDTH_INTERNAL_PV-1:0] dout0,
  output logic [WIDTH_INTERNAL_PV-1:0] dout1,
  output logic [WIDTH_INTERNAL_PV-1:0] dout2,
  output logic [WIDTH_INTERNAL_PV-1:0] dout3,
  output logic [3:0]                   out_valid,
  output logic [1:0]                   golden_port,
  output logic                         sat_event
);

  localparam int FW = WIDTH_INTERNAL_PV;
  localparam int AL = POS_TIME_LSB;
  localparam logic [TIME_W-1:0] AGE_MAX =
    TIME_W'(age_max(TIME_W));

  logic [3:0][FW-1:0]     w_din;
  logic [3:0][FW-1:0]     w_sel;
  logic [3:0][FW-1:0]     w_ndata;
  logic [3:0][FW-1:0]     w_dout;
  logic [3:0][TIME_W-1:0] w_inc_in;
  logic [3:0][TIME_W-1:0] w_inc_out;
  logic [3:0]             w_hit;
  logic [3:0]             w_nvalid;
  logic [1:0]             w_golden;

  logic [3:0][FW-1:0]     r_data;
  logic [3:0]             r_valid;
  logic                   r_sat;

  assign w_din    = {din3, din2, din1, din0};
  assign w_sel    = hold ? r_data : w_din;
  assign w_nvalid = hold ? r_valid : in_valid;

  always_comb begin
    w_inc_in = '0;
    for (int i = 0; i < 4; i++)
      w_inc_in[i] = w_sel[i][AL +: TIME_W];
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    age_sat_inc #(.W(TIME_W)) u_inc (
      .i_age (w_inc_in[g]),
      .i_max (AGE_MAX),
      .o_age (w_inc_out[g]),
      .o_hit (w_hit[g])
    );
  end

  // Empty slots carry age 0 so they sort last.
  always_comb begin
    w_ndata = w_sel;
    for (int i = 0; i < 4; i++)
      w_ndata[i][AL +: TIME_W] =
        w_nvalid[i] ? w_inc_out[i] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_data  <= w_ndata;
      r_valid <= w_nvalid;
      r_sat   <= |(w_hit & w_nvalid);
    end
  end

`ifdef PN_GOLDEN_EN
  localparam int EW = $clog2(EPOCH_LEN);

  logic [EW-1:0] r_epoch;
  logic [1:0]    r_golden;

  // Epoch runs through stalls so a held flit can lose golden.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epoch  <= '0;
      r_golden <= '0;
    end else if (r_epoch == EW'(EPOCH_LEN - 1)) begin
      r_epoch  <= '0;
      r_golden <= r_golden + 2'd1;
    end else begin
      r_epoch  <= r_epoch + EW'(1);
    end
  end

  assign w_golden = r_golden;

  // Override lives only on the output, never in the stored age.
  always_comb begin
    w_dout = r_data;
    for (int i = 0; i < 4; i++)
      if (r_valid[i] && w_golden == 2'(i))
        w_dout[i][AL +: TIME_W] = '1;
  end
`else
  logic w_unused_epoch;

  assign w_unused_epoch = (EPOCH_LEN < 2);
  assign w_golden       = 2'd0;
  assign w_dout         = r_data;
`endif

  assign dout0       = w_dout[0];
  assign dout1       = w_dout[1];
  assign dout2       = w_dout[2];
  assign dout3       = w_dout[3];
  assign out_valid   = r_valid;
  assign golden_port = w_golden;
  assign sat_event   = r_sat;

endmodule

// File: tb/tb_pn_age_scheduler.sv
// tb_pn_age_scheduler: directed plus random checks of pn_age_scheduler
// against a cycle-level reference model of aging and golden rotation.
module tb_pn_age_scheduler;

  localparam int EP = 4;
  localparam int TW = 8;
  localparam int TOP = (1 << TW) - 1;
`ifdef PN_GOLDEN_EN
  localparam bit GOLD = 1'b1;
  localparam int AMAX = TOP - 1;
`else
  localparam bit GOLD = 1'b0;
  localparam int AMAX = TOP;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] t_din [4];
  logic [31:0] dout0, dout1, dout2, dout3;
  logic [3:0]  out_valid;
  logic [1:0]  golden_port;
  logic        sat_event;

  int          n_cmp = 0;
  int          n_mis = 0;

  bit          m_val [4];
  int          m_age [4];
  logic [31:0] m_dat [4];
  bit          m_sat;
  int          m_k;
  bit          m_rst;

  always #5 clk = ~clk;

  pn_age_scheduler #(.TIME_W(TW), .EPOCH_LEN(EP)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .din0        (t_din[0]),
    .din1        (t_din[1]),
    .din2        (t_din[2]),
    .din3        (t_din[3]),
    .hold        (hold),
    .dout0       (dout0),
    .dout1       (dout1),
    .dout2       (dout2),
    .dout3       (dout3),
    .out_valid   (out_valid),
    .golden_port (golden_port),
    .sat_event   (sat_event)
  );

  function automatic logic [31:0] mk(input int age);
    logic [31:0] r;
    logic [31:0] a;
    r = $urandom;
    a = age;
    r[23:16] = a[7:0];
    return r;
  endfunction

  function automatic int sat_inc(input int a);
    return (a + 1 > AMAX) ? AMAX : a + 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int old;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 1'b0;
        m_age[i] = 0;
        m_dat[i] = '0;
      end
      m_sat = 1'b0;
      m_k   = 0;
      m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    m_k++;
    m_sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (hold) begin
        old = m_age[i];
      end else begin
        m_val[i] = in_valid[i];
        m_dat[i] = t_din[i];
        old = int'(t_din[i][23:16]);
      end
      if (m_val[i]) begin
        m_age[i] = sat_inc(old);
        if (m_age[i] == AMAX && old < AMAX) m_sat = 1'b1;
      end else begin
        m_age[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] obs [4];
    logic [31:0] exp;
    logic [31:0] ea;
    int gp;
    obs[0] = dout0;
    obs[1] = dout1;
    obs[2] = dout2;
    obs[3] = dout3;
    gp = GOLD ? (m_k / EP) % 4 : 0;
    chk({tag, ".valid"}, 32'(out_valid),
        32'({m_val[3], m_val[2], m_val[1], m_val[0]}));
    chk({tag, ".golden"}, 32'(golden_port), 32'(gp));
    chk({tag, ".sat"}, 32'(sat_event), 32'(m_sat));
    for (int i = 0; i < 4; i++) begin
      string st;
      st = $sformatf("%s.dout%0d", tag, i);
      if (m_rst) begin
        chk(st, obs[i], 32'h0);
      end else if (m_val[i]) begin
        exp = m_dat[i];
        ea = (GOLD && i == gp) ? TOP : m_age[i];
        exp[23:16] = ea[7:0];
        chk(st, obs[i], exp);
      end else begin
        chk({st, ".age"}, 32'(obs[i][23:16]), 32'h0);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit r, input bit h,
                        input logic [3:0] v,
                        input int a0, input int a1,
                        input int a2, input int a3);
    reset    = r;
    hold     = h;
    in_valid = v;
    t_din[0] = mk(a0);
    t_din[1] = mk(a1);
    t_din[2] = mk(a2);
    t_din[3] = mk(a3);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) t_din[i] = '0;

    set_in(1, 0, 4'b1111, 1, 2, 3, 4);
    tick("reset0");
    tick("reset1");

    set_in(0, 0, 4'b1111, 3, 5, 7, 9);
    tick("load3579");

    set_in(0, 0, 4'b0100, 50, 60, 100, 70);
    tick("load100");
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1, 4'b1011, 1, 2, 3, 4);
      tick($sformatf("hold100_%0d", c));
    end

    set_in(0, 0, 4'b0001, AMAX - 3, 0, 0, 0);
    tick("load_nearmax");
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1, 4'b0000, 9, 9, 9, 9);
      tick($sformatf("sat_%0d", c));
    end

    set_in(0, 0, 4'b0001, TOP, 0, 0, 0);
    tick("load_top");

    for (int c = 0; c < 12; c++) begin
      set_in(0, c % 3 == 1, 4'b1111, 10, 10, 10, 10);
      tick($sformatf("epoch_%0d", c));
    end

    set_in(0, 0, 4'b1111, 20, 30, 40, 50);
    tick("preload");
    set_in(0, 1, 4'b1111, 1, 1, 1, 1);
    tick("stall");
    set_in(1, 1, 4'b1111, 1, 1, 1, 1);
    tick("rst_in_hold");

    for (int c = 0; c < 400; c++) begin
      int a [4];
      for (int i = 0; i < 4; i++)
        a[i] = ($urandom_range(0, 1) == 1) ?
               $urandom_range(AMAX - 4, TOP) :
               $urandom_range(0, TOP);
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 2) == 0,
             4'($urandom_range(0, 15)),
             a[0], a[1], a[2], a[3]);
      tick($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
